// File: rtl/spi_target_sync.sv
// Purpose: SPI mode-0 target, MSB first, 8-bit words, oversampled in the clk domain.
// Latency: sclk/cs/mosi seen 2-3 clk after the pin; rx_data/rx_valid 1 clk after the 8th sampled sclk rise.
// Backpressure: tx via valid/ready holding register; rx_valid held until rx_ready (overrun drop if SPI_TARGET_RX_OVERRUN_EN).
//
// Ports:
//   clk, rst (async active-low)      - system clock and reset
//   sclk, cs, mosi                   - SPI pins from master (asynchronous)
//   miso, miso_oe                    - SPI data to master and pad enable
//   tx_data/tx_valid/tx_ready        - next transmit byte handshake
//   rx_data/rx_valid/rx_ready        - received byte handshake
//   frame_abort                      - 1-clk pulse when cs rises mid-byte
//   rx_overrun                       - only with SPI_TARGET_RX_OVERRUN_EN: 1-clk pulse on dropped byte
module spi_target_sync #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_abort
`ifdef SPI_TARGET_RX_OVERRUN_EN
  ,
  output logic       rx_overrun
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  // Synchronizer chains; the 3rd stage exists only for edge detection.
  logic       r_cs_s1, r_cs_s2, r_cs_s3;
  logic       r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic       r_mosi_s1, r_mosi_s2;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_hold;
  logic       r_tx_ready;     // holding register empty
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_byte_done;    // rx_shift holds a completed byte this cycle
  logic       r_frame_abort;
  logic       r_rx_overrun;

  logic       w_cs_fall;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_tx_wr;
  logic [7:0] w_reload_byte;

  assign w_cs_fall     = ~r_cs_s2 & r_cs_s3;
  assign w_sclk_rise   = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall   = ~r_sclk_s2 & r_sclk_s3;
  assign w_tx_wr       = tx_valid & r_tx_ready;
  // Reload always sees the pre-write holding content: an empty register yields IDLE_BYTE.
  assign w_reload_byte = r_tx_ready ? IDLE_BYTE : r_hold;

  assign miso        = (r_state != S_IDLE) & r_tx_shift[7];
  assign miso_oe     = ~r_cs_s2;
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_abort = r_frame_abort;
`ifdef SPI_TARGET_RX_OVERRUN_EN
  assign rx_overrun  = r_rx_overrun;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 8'h00;
      r_tx_shift    <= 8'h00;
      r_hold        <= 8'h00;
      r_tx_ready    <= 1'b1;
      r_rx_data     <= 8'h00;
      r_rx_valid    <= 1'b0;
      r_byte_done   <= 1'b0;
      r_frame_abort <= 1'b0;
      r_rx_overrun  <= 1'b0;
    end else begin
      r_frame_abort <= 1'b0;
      r_rx_overrun  <= 1'b0;
      r_byte_done   <= 1'b0;

      // Receive output stage, one cycle behind the completing sclk edge.
      if (r_byte_done) begin
`ifdef SPI_TARGET_RX_OVERRUN_EN
        if (r_rx_valid && !rx_ready) begin
          r_rx_overrun <= 1'b1;
        end else begin
          r_rx_data  <= r_rx_shift;
          r_rx_valid <= 1'b1;
        end
`else
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
`endif
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_tx_wr) begin
        r_hold <= tx_data;
      end

      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= 3'd0;
          if (w_cs_fall) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_cs_s2) begin
            r_state <= S_IDLE;
          end else begin
            r_tx_shift <= w_reload_byte;
            r_tx_ready <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cs_s2) begin
            // Partial byte is dropped simply by restarting the bit count.
            r_state       <= S_IDLE;
            r_frame_abort <= (r_bit_cnt != 3'd0);
            r_bit_cnt     <= 3'd0;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[6:0], r_mosi_s2};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_byte_done <= (r_bit_cnt == 3'd7);
            end
            if (w_sclk_fall) begin
              if (r_bit_cnt == 3'd0) begin
                r_tx_shift <= w_reload_byte;
                r_tx_ready <= 1'b1;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A same-cycle write keeps the new byte held, overriding any reload's ready.
      if (w_tx_wr) begin
        r_tx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target_sync.sv
module tb_spi_target_sync;

  localparam time HALF = 80ns;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_abort;
`ifdef SPI_TARGET_RX_OVERRUN_EN
  logic       rx_overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int abort_cycles = 0;
  int ovr_cycles   = 0;
  logic [7:0] exp_rx_q[$];

  spi_target_sync #(.IDLE_BYTE(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_abort (frame_abort)
`ifdef SPI_TARGET_RX_OVERRUN_EN
    ,
    .rx_overrun  (rx_overrun)
`endif
  );

  always #5ns clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx handshake pops one expected byte.
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_data);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx_q.pop_front()});
      end
    end
    if (frame_abort) abort_cycles++;
`ifdef SPI_TARGET_RX_OVERRUN_EN
    if (rx_overrun) ovr_cycles++;
`endif
  end

  task automatic push_tx(input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("tx_ready_wait", {31'h0, tx_ready}, 32'h1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1ns;
    tx_valid = 1'b0;
  endtask

  // Master side: mode 0, MSB first; miso sampled just as sclk rises.
  task automatic spi_xfer(input logic [7:0] d, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = d[i];
      #HALF;
      r[i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    #200ns;
  endtask

  task automatic cs_end();
    #HALF;
    cs = 1'b1;
    #300ns;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000 && exp_rx_q.size() > 0; i++) @(posedge clk);
    check(name, exp_rx_q.size(), 0);
  endtask

  logic [7:0] got;

  initial begin
    repeat (3) @(posedge clk);
    #1ns;
    check("rst_miso",        {31'h0, miso},        32'h0);
    check("rst_miso_oe",     {31'h0, miso_oe},     32'h0);
    check("rst_tx_ready",    {31'h0, tx_ready},    32'h1);
    check("rst_rx_data",     {24'h0, rx_data},     32'h0);
    check("rst_rx_valid",    {31'h0, rx_valid},    32'h0);
    check("rst_frame_abort", {31'h0, frame_abort}, 32'h0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Queued byte out, D5 in.
    push_tx(8'hAA);
    #1ns;
    check("tx_ready_after_write", {31'h0, tx_ready}, 32'h0);
    cs_start();
    check("tx_ready_after_load", {31'h0, tx_ready}, 32'h1);
    check("miso_oe_active",      {31'h0, miso_oe},  32'h1);
    exp_rx_q.push_back(8'hD5);
    spi_xfer(8'hD5, 8, got);
    check("miso_byte_AA", {24'h0, got}, 32'hAA);
    cs_end();
    wait_drain("drain_D5");

    // Nothing queued: idle byte out.
    cs_start();
    exp_rx_q.push_back(8'h3C);
    spi_xfer(8'h3C, 8, got);
    check("miso_idle_FF", {24'h0, got}, 32'hFF);
    cs_end();
    wait_drain("drain_3C");

    // Two-byte frame, second tx byte queued inside the frame.
    push_tx(8'h12);
    cs_start();
    push_tx(8'h34);
    exp_rx_q.push_back(8'hA1);
    spi_xfer(8'hA1, 8, got);
    check("miso_byte_12", {24'h0, got}, 32'h12);
    exp_rx_q.push_back(8'hB2);
    spi_xfer(8'hB2, 8, got);
    check("miso_byte_34", {24'h0, got}, 32'h34);
    cs_end();
    wait_drain("drain_A1_B2");

    // Abort after 3 bits, then a clean frame.
    check("no_abort_yet", abort_cycles, 0);
    cs_start();
    spi_xfer(8'hF0, 3, got);
    cs_end();
    check("abort_one_pulse", abort_cycles, 1);
    check("abort_no_rx_valid", {31'h0, rx_valid}, 32'h0);
    cs_start();
    exp_rx_q.push_back(8'h5A);
    spi_xfer(8'h5A, 8, got);
    cs_end();
    wait_drain("drain_5A");
    check("abort_clean_frame", abort_cycles, 1);

    // Consumer stalled across two completed bytes.
    @(posedge clk);
    #1ns;
    rx_ready = 1'b0;
    cs_start();
    spi_xfer(8'h01, 8, got);
    spi_xfer(8'h02, 8, got);
    cs_end();
    check("stall_rx_valid", {31'h0, rx_valid}, 32'h1);
`ifdef SPI_TARGET_RX_OVERRUN_EN
    check("overrun_rx_data", {24'h0, rx_data}, 32'h01);
    check("overrun_one_pulse", ovr_cycles, 1);
    exp_rx_q.push_back(8'h01);
`else
    check("overwrite_rx_data", {24'h0, rx_data}, 32'h02);
    exp_rx_q.push_back(8'h02);
`endif
    @(posedge clk);
    #1ns;
    rx_ready = 1'b1;
    wait_drain("drain_stall");

    // Reset during bit 4 of a byte.
    cs_start();
    spi_xfer(8'h99, 4, got);
    #20ns;
    rst = 1'b0;
    #1ns;
    check("midrst_miso",        {31'h0, miso},        32'h0);
    check("midrst_miso_oe",     {31'h0, miso_oe},     32'h0);
    check("midrst_tx_ready",    {31'h0, tx_ready},    32'h1);
    check("midrst_rx_data",     {24'h0, rx_data},     32'h0);
    check("midrst_rx_valid",    {31'h0, rx_valid},    32'h0);
    check("midrst_frame_abort", {31'h0, frame_abort}, 32'h0);
    cs = 1'b1;
    #100ns;
    @(posedge clk);
    #1ns;
    rst = 1'b1;
    #200ns;
    cs_start();
    exp_rx_q.push_back(8'hC3);
    spi_xfer(8'hC3, 8, got);
    check("post_rst_miso_FF", {24'h0, got}, 32'hFF);
    cs_end();
    wait_drain("drain_C3");
    check("total_abort_pulses", abort_cycles, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
